tmr_event_counter: RTL

Triplicated, self-correcting event counter for the radiation-tolerant test designs mapped onto the 65 nm standard-cell library (full/half adders, majority and D-flop cells). Counts single-cycle event strobes into three redundant copies, majority-votes them every cycle, rewrites all copies from the voted value and reports disagreements (SEUs). A snapshot-and-clear read port with a valid/ack handshake feeds the downstream readout logic.

---
 rtl/tmr_event_counter.sv | 113 +++++++++++
 1 files changed

// File: rtl/tmr_event_counter.sv
// Triplicated event counter: three copies are majority-voted every cycle and all
// reloaded from the vote, which scrubs single-copy upsets. Includes a snapshot-and-clear read port.
module tmr_event_counter #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic [2:0]       inj,
  output logic [WIDTH-1:0] cnt,
  output logic             sat,
  input  logic             rd_req,
  output logic             rd_valid,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             seu_err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0]  ERR_MAX = {ERRW{1'b1}};
  localparam logic [ERRW-1:0]  ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [WIDTH-1:0] cnt_a_d, cnt_b_d, cnt_c_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             seu_err_q, seu_err_d;
  logic [ERRW-1:0]  err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] voted;
  logic [WIDTH-1:0] next_cnt;
  logic             mismatch;
  logic             rd_accept;

  function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Counting holds at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] cnt_sat_inc(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  function automatic logic [ERRW-1:0] err_sat_inc(input logic [ERRW-1:0] e);
    return (e == ERR_MAX) ? e : e + ERR_ONE;
  endfunction

  assign voted     = vote3(cnt_a_q, cnt_b_q, cnt_c_q);
  assign mismatch  = (cnt_a_q != voted) | (cnt_b_q != voted) | (cnt_c_q != voted);
  assign rd_accept = rd_req & ~rd_valid_q & ~clr;

  always_comb begin
    next_cnt = voted;
    if (clr) begin
      next_cnt = '0;
    end else if (rd_accept) begin
      // The event arriving alongside the snapshot belongs to the new interval.
      next_cnt = inc ? CNT_ONE : '0;
    end else if (inc) begin
      next_cnt = cnt_sat_inc(voted);
    end
  end

  always_comb begin
    cnt_a_d    = next_cnt ^ {{(WIDTH-1){1'b0}}, inj[0]};
    cnt_b_d    = next_cnt ^ {{(WIDTH-1){1'b0}}, inj[1]};
    cnt_c_d    = next_cnt ^ {{(WIDTH-1){1'b0}}, inj[2]};
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_accept) begin
      rd_valid_d = 1'b1;
      rd_data_d  = voted;
    end else if (rd_valid_q && rd_ack) begin
      rd_valid_d = 1'b0;
    end
    seu_err_d = mismatch;
    err_cnt_d = seu_err_q ? err_sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      cnt_c_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      seu_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      cnt_c_q    <= cnt_c_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      seu_err_q  <= seu_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign cnt      = voted;
  assign sat      = (voted == CNT_MAX);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign seu_err  = seu_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
